sa_result_drain: RTL and testbench
==================================

# sa_result_drain

Unloads the systolic-array result bus. On a capture strobe it snapshots the full flat `HPE*VPE` result vector produced by the 2-D array core and streams it out one PE result per beat over a valid/ready interface, so a narrow consumer (memory writer, host port) can read results without holding the wide bus. It sits directly downstream of the registered array output and forms the read side of the array's result path.

## Interface
- `HPE`, default 4: horizontal processing elements.
- `VPE`, default 4: vertical processing elements.
- `WIDTH`, default 16: operand width. Each PE result is `2*WIDTH` bits.
- `CLK`  in  1: the only clock. All logic is on the rising edge.
- `RST`  in  1: reset, synchronous and active-high.
- `YY`  in  `2*WIDTH*HPE*VPE`: flat result vector. PE `k` occupies `YY[2*WIDTH*k +: 2*WIDTH]`.
- `CAP`  in  1: capture strobe. It is single-cycle and qualifies `YY`.
- `OUT_READY`  in  1: the consumer accepts the current beat.
- `OUT_VALID`  out  1: the beat is valid.
- `OUT_DATA`  out  `2*WIDTH`, or `WIDTH` under `SA_DRAIN_SAT_EN`: the PE result.
- `OUT_IDX`  out  `$clog2(HPE*VPE)`: PE index `k` of the current beat.
- `OUT_LAST`  out  1: asserted when `OUT_IDX == HPE*VPE-1`.
- `BUSY`  out  1: the drain is in progress, meaning state is DRAIN.
- `OVF`  out  1: one-cycle pulse when a `CAP` is dropped.

## Operation
- States are IDLE and DRAIN.
- Reset values: state IDLE; `OUT_VALID`, `OUT_DATA`, `OUT_IDX`, `OUT_LAST`, `BUSY`, `OVF` all 0; shadow register 0.
- IDLE with `CAP=1`:
  - Latch `YY` into the shadow register.
  - Set index to 0.
  - Go to DRAIN.
- DRAIN:
  - `OUT_VALID=1`, and `OUT_DATA` = shadow slice at the current index.
  - A transfer occurs when `OUT_VALID && OUT_READY`.
  - On a transfer with index < `NPE-1`, increment the index.
  - On a transfer with index = `NPE-1`, go to IDLE. If `CAP=1` in that same cycle, instead relatch `YY`, reset the index to 0 and stay in DRAIN.
- Handshake rules:
  - Once asserted, `OUT_VALID` stays high until the transfer.
  - `OUT_DATA`, `OUT_IDX` and `OUT_LAST` are stable while `OUT_VALID && !OUT_READY`.
  - `OUT_VALID` never depends combinationally on `OUT_READY`.
- Overflow:
  - `CAP` in DRAIN, other than on the final transfer cycle, is ignored.
  - The shadow register is untouched.
  - `OVF` pulses on the following cycle.
- Order is ascending `k`. `k = r*HPE + c` matches the core's flat packing.
- Reset mid-drain: on the next edge the block is IDLE, `OUT_VALID=0`, and the remaining beats are discarded with no `OVF`.
- `RST` and `CAP` in the same cycle: `RST` wins and no capture occurs.

## Timing
- The only timing source is `CLK`; there are no combinational input-to-output paths.
- `CAP` accepted at edge t: first beat (`OUT_IDX=0`) is valid after edge t, i.e. in cycle t+1.
- With `OUT_READY` held high, `NPE` beats occupy cycles t+1 .. t+NPE. `BUSY` falls after the last transfer edge.
- A back-to-back `CAP` on the last transfer gives zero bubble cycles between frames.
- Throughput is one result per cycle.

## Configuration
- Macro: `SA_DRAIN_SAT_EN`.
- Defined:
  - `OUT_DATA` is `WIDTH` bits.
  - Each signed `2*WIDTH` result is saturated to the signed `WIDTH` range, clamping to `2^(WIDTH-1)-1` or `-2^(WIDTH-1)`.
  - The saturation is combinational on the shadow slice, so latency is unchanged.
- Undefined: `OUT_DATA` is the raw `2*WIDTH` result.

## Structure
- Package `sa_drain_pkg` holds:
  - the state enum (IDLE, DRAIN);
  - `NPE = HPE*VPE`;
  - `IDXW = $clog2(NPE)`, with a minimum of 1;
  - `RW = 2*WIDTH`.
- Sub-module `sa_drain_sat`: a parameterised signed saturator from `RW` to `WIDTH`. It is instantiated only under `SA_DRAIN_SAT_EN`.

## Test plan
All scenarios use `HPE=2`, `VPE=2`, `WIDTH=16`, so `NPE=4`.
1. Basic drain:
   - `YY = {32'h4, 32'h3, 32'h2, 32'h1}`, `CAP` for 1 cycle, `OUT_READY=1`.
   - Required: beats 1, 2, 3, 4 on cycles t+1..t+4, `OUT_IDX` 0..3, `OUT_LAST` only on idx 3, then `BUSY=0`.
2. Backpressure:
   - `OUT_READY` toggles 0/1 every cycle.
   - Required: each beat is held stable while ready is low, all 4 values arrive in order, and the drain takes 8 cycles.
3. Back-to-back frames:
   - A second `CAP` with `YY = {32'h8, 32'h7, 32'h6, 32'h5}` arrives on the idx-3 transfer cycle.
   - Required: beat 5 (idx 0) in the very next cycle, no gap.
4. Overflow:
   - `CAP` with new `YY` at idx 1.
   - Required: `OVF` high for exactly 1 cycle, and the stream still outputs the original values 2, 3, 4.
5. Reset mid-drain:
   - `RST` at idx 2.
   - Required: next cycle `OUT_VALID=0`, `BUSY=0`, all outputs 0; a later `CAP` restarts at idx 0.
6. `SA_DRAIN_SAT_EN` defined:
   - `YY` slices 32'h0001_0000, 32'hFFFE_0000, 32'h0000_7FFF, 32'hFFFF_8000.
   - Required: outputs 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000.

Source files
------------

// File: rtl/sa_result_drain_pkg.sv
// Shared types and sizing helpers for the systolic-array result drain.
// Build option SA_DRAIN_SAT_EN narrows OUT_DATA to WIDTH with signed saturation.
package sa_drain_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int HPE_D   = 4;
    localparam int VPE_D   = 4;
    localparam int WIDTH_D = 16;

    localparam int NPE  = HPE_D * VPE_D;
    localparam int IDXW = (NPE > 1) ? $clog2(NPE) : 1;
    localparam int RW   = 2 * WIDTH_D;

    // Index width for an arbitrary PE count; a single PE still needs one bit.
    function automatic int idxw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_result_drain_if.sv
// Beat-stream interface between the result drain and its narrow consumer.
interface sa_result_drain_if #(
    parameter int DW = 32,
    parameter int IW = 4
);
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [DW-1:0] OUT_DATA;
    logic [IW-1:0] OUT_IDX;
    logic          OUT_LAST;

    modport master (
        output OUT_VALID, OUT_DATA, OUT_IDX, OUT_LAST,
        input  OUT_READY
    );

    modport slave (
        input  OUT_VALID, OUT_DATA, OUT_IDX, OUT_LAST,
        output OUT_READY
    );
endinterface

// File: rtl/sa_result_drain_sat.sv
// Signed saturator from IW to OW bits, used by the drain when SA_DRAIN_SAT_EN is set.
module sa_drain_sat #(
    parameter int IW = 32,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout
);

    // In range exactly when every bit from the output sign bit upward agrees.
    function automatic logic signed [OW-1:0] sat(input logic signed [IW-1:0] v);
        logic [IW-OW:0] top;
        top = v[IW-1:OW-1];
        if ((&top) || !(|top))
            return v[OW-1:0];
        else if (v[IW-1])
            return {1'b1, {(OW-1){1'b0}}};
        else
            return {1'b0, {(OW-1){1'b1}}};
    endfunction

    assign dout = sat(din);

endmodule

// File: rtl/sa_result_drain.sv
// Snapshots the flat HPE*VPE result vector on CAP and streams one PE result per beat.
// Build option SA_DRAIN_SAT_EN: OUT_DATA becomes WIDTH bits, saturated from 2*WIDTH.
module sa_result_drain
    import sa_drain_pkg::*;
#(
    parameter int HPE   = HPE_D,
    parameter int VPE   = VPE_D,
    parameter int WIDTH = WIDTH_D
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [2*WIDTH*HPE*VPE-1:0]   YY,
    input  logic                         CAP,
    sa_result_drain_if.master            dout,
    output logic                         BUSY,
    output logic                         OVF
);

    localparam int NPE  = HPE * VPE;
    localparam int IDXW = idxw_of(NPE);
    localparam int RW   = 2 * WIDTH;
`ifdef SA_DRAIN_SAT_EN
    localparam int DW = WIDTH;
`else
    localparam int DW = RW;
`endif

    state_t                state_p0, state_nx;
    logic [IDXW-1:0]       idx_p0, idx_nx;
    logic [NPE*RW-1:0]     shadow_p0;
    logic                  ovf_p0, ovf_nx;
    logic                  load;
    logic                  vld_p0;
    logic                  last;
    logic                  xfer;
    logic signed [RW-1:0]  slice;
    logic [DW-1:0]         beat;

    assign vld_p0 = (state_p0 == DRAIN);
    assign last   = (idx_p0 == IDXW'(NPE - 1));
    assign xfer   = vld_p0 && dout.OUT_READY;

    always_comb begin
        state_nx = state_p0;
        idx_nx   = idx_p0;
        load     = 1'b0;
        ovf_nx   = 1'b0;
        case (state_p0)
            IDLE: begin
                if (CAP) begin
                    load     = 1'b1;
                    idx_nx   = '0;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && last) begin
                    idx_nx = '0;
                    if (CAP) begin
                        load     = 1'b1;
                        state_nx = DRAIN;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    if (xfer)
                        idx_nx = idx_p0 + 1'b1;
                    // A capture mid-frame would corrupt the beats still owed.
                    if (CAP)
                        ovf_nx = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = '0;
            end
        endcase
    end

    // Stage p0: state, index, overflow flag and the captured frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_p0  <= IDLE;
            idx_p0    <= '0;
            ovf_p0    <= 1'b0;
            shadow_p0 <= '0;
        end else begin
            state_p0 <= state_nx;
            idx_p0   <= idx_nx;
            ovf_p0   <= ovf_nx;
            if (load)
                shadow_p0 <= YY;
        end
    end

    assign slice = shadow_p0[int'(idx_p0)*RW +: RW];

`ifdef SA_DRAIN_SAT_EN
    logic signed [WIDTH-1:0] sat_data;

    sa_drain_sat #(
        .IW (RW),
        .OW (WIDTH)
    ) u_sat (
        .din  (slice),
        .dout (sat_data)
    );

    assign beat = sat_data;
`else
    assign beat = slice;
`endif

    // Outputs derive only from registered state, so nothing follows OUT_READY combinationally.
    assign dout.OUT_VALID = vld_p0;
    assign dout.OUT_DATA  = vld_p0 ? beat : '0;
    assign dout.OUT_IDX   = idx_p0;
    assign dout.OUT_LAST  = vld_p0 && last;
    assign BUSY           = vld_p0;
    assign OVF            = ovf_p0;

endmodule

// File: tb/tb_sa_result_drain.sv
// Table-driven bench for sa_result_drain with HPE=2, VPE=2, WIDTH=16.
module tb_sa_result_drain;

    localparam int HPE   = 2;
    localparam int VPE   = 2;
    localparam int WIDTH = 16;
`ifdef SA_DRAIN_SAT_EN
    localparam int DW = WIDTH;
`else
    localparam int DW = 2 * WIDTH;
`endif

    typedef struct {
        logic        rst;
        logic        cap;
        logic        rdy;
        int          ysel;
        logic        v;
        logic [31:0] d;
        logic [1:0]  i;
        logic        l;
        logic        b;
        logic        o;
    } vec_t;

    logic         CLK;
    logic         RST;
    logic         CAP;
    logic [127:0] YY;
    logic         BUSY;
    logic         OVF;

    sa_result_drain_if #(.DW(DW), .IW(2)) dif ();

    sa_result_drain #(
        .HPE   (HPE),
        .VPE   (VPE),
        .WIDTH (WIDTH)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .YY   (YY),
        .CAP  (CAP),
        .dout (dif),
        .BUSY (BUSY),
        .OVF  (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] YA = {32'h4, 32'h3, 32'h2, 32'h1};
    localparam logic [127:0] YB = {32'h8, 32'h7, 32'h6, 32'h5};
    localparam logic [127:0] YC = {32'hDEAD_0004, 32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001};
    localparam logic [127:0] YD = {32'hFFFF_8000, 32'h0000_7FFF, 32'hFFFE_0000, 32'h0001_0000};

    function automatic logic [127:0] ysel_to_yy(input int s);
        case (s)
            1: return YA;
            2: return YB;
            3: return YC;
            4: return YD;
            default: return '0;
        endcase
    endfunction

    function automatic vec_t mk(input logic rst, input logic cap, input logic rdy, input int ysel,
                                input logic v, input logic [31:0] d, input logic [1:0] i,
                                input logic l, input logic b, input logic o);
        vec_t r;
        r.rst = rst; r.cap = cap; r.rdy = rdy; r.ysel = ysel;
        r.v = v; r.d = d; r.i = i; r.l = l; r.b = b; r.o = o;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic v, input logic [31:0] d,
                                 input logic [1:0] i, input logic l, input logic b, input logic o);
        logic [DW-1:0] dexp;
        dexp = d[DW-1:0];
        chk({tag, " valid"}, 32'(dif.OUT_VALID), 32'(v));
        chk({tag, " data"},  32'(dif.OUT_DATA),  32'(dexp));
        chk({tag, " idx"},   32'(dif.OUT_IDX),   32'(i));
        chk({tag, " last"},  32'(dif.OUT_LAST),  32'(l));
        chk({tag, " busy"},  32'(BUSY),          32'(b));
        chk({tag, " ovf"},   32'(OVF),           32'(o));
    endtask

    vec_t tbl[29];

    initial begin
        // Each row: inputs driven this cycle, outputs expected during this cycle.
        //               rst  cap  rdy ysel  v  data   i  l  b  o
        tbl[0]  = mk(1'b0,1'b1,1'b1,1, 1'b0,32'h0,2'd0,1'b0,1'b0,1'b0);
        tbl[1]  = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h1,2'd0,1'b0,1'b1,1'b0);
        tbl[2]  = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h2,2'd1,1'b0,1'b1,1'b0);
        tbl[3]  = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h3,2'd2,1'b0,1'b1,1'b0);
        tbl[4]  = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h4,2'd3,1'b1,1'b1,1'b0);
        tbl[5]  = mk(1'b0,1'b1,1'b0,1, 1'b0,32'h0,2'd0,1'b0,1'b0,1'b0);
        tbl[6]  = mk(1'b0,1'b0,1'b0,0, 1'b1,32'h1,2'd0,1'b0,1'b1,1'b0);
        tbl[7]  = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h1,2'd0,1'b0,1'b1,1'b0);
        tbl[8]  = mk(1'b0,1'b0,1'b0,0, 1'b1,32'h2,2'd1,1'b0,1'b1,1'b0);
        tbl[9]  = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h2,2'd1,1'b0,1'b1,1'b0);
        tbl[10] = mk(1'b0,1'b0,1'b0,0, 1'b1,32'h3,2'd2,1'b0,1'b1,1'b0);
        tbl[11] = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h3,2'd2,1'b0,1'b1,1'b0);
        tbl[12] = mk(1'b0,1'b0,1'b0,0, 1'b1,32'h4,2'd3,1'b1,1'b1,1'b0);
        tbl[13] = mk(1'b0,1'b1,1'b1,2, 1'b1,32'h4,2'd3,1'b1,1'b1,1'b0);
        tbl[14] = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h5,2'd0,1'b0,1'b1,1'b0);
        tbl[15] = mk(1'b0,1'b1,1'b1,3, 1'b1,32'h6,2'd1,1'b0,1'b1,1'b0);
        tbl[16] = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h7,2'd2,1'b0,1'b1,1'b1);
        tbl[17] = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h8,2'd3,1'b1,1'b1,1'b0);
        tbl[18] = mk(1'b0,1'b1,1'b1,1, 1'b0,32'h0,2'd0,1'b0,1'b0,1'b0);
        tbl[19] = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h1,2'd0,1'b0,1'b1,1'b0);
        tbl[20] = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h2,2'd1,1'b0,1'b1,1'b0);
        tbl[21] = mk(1'b1,1'b1,1'b0,2, 1'b1,32'h3,2'd2,1'b0,1'b1,1'b0);
        tbl[22] = mk(1'b0,1'b0,1'b1,0, 1'b0,32'h0,2'd0,1'b0,1'b0,1'b0);
        tbl[23] = mk(1'b0,1'b1,1'b1,2, 1'b0,32'h0,2'd0,1'b0,1'b0,1'b0);
        tbl[24] = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h5,2'd0,1'b0,1'b1,1'b0);
        tbl[25] = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h6,2'd1,1'b0,1'b1,1'b0);
        tbl[26] = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h7,2'd2,1'b0,1'b1,1'b0);
        tbl[27] = mk(1'b0,1'b0,1'b1,0, 1'b1,32'h8,2'd3,1'b1,1'b1,1'b0);
        tbl[28] = mk(1'b0,1'b0,1'b1,0, 1'b0,32'h0,2'd0,1'b0,1'b0,1'b0);

        RST = 1'b1;
        CAP = 1'b0;
        YY  = '0;
        dif.OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);

        for (int n = 0; n < 29; n++) begin
            @(negedge CLK);
            check_outputs($sformatf("row%0d", n), tbl[n].v, tbl[n].d, tbl[n].i,
                          tbl[n].l, tbl[n].b, tbl[n].o);
            RST = tbl[n].rst;
            CAP = tbl[n].cap;
            dif.OUT_READY = tbl[n].rdy;
            YY  = ysel_to_yy(tbl[n].ysel);
        end

        // Saturation frame: raw slices, or clamped values when the option is built in.
        begin
            logic [31:0] sexp[4];
`ifdef SA_DRAIN_SAT_EN
            sexp[0] = 32'h7FFF; sexp[1] = 32'h8000; sexp[2] = 32'h7FFF; sexp[3] = 32'h8000;
`else
            sexp[0] = 32'h0001_0000; sexp[1] = 32'hFFFE_0000;
            sexp[2] = 32'h0000_7FFF; sexp[3] = 32'hFFFF_8000;
`endif
            @(negedge CLK);
            RST = 1'b0;
            CAP = 1'b1;
            YY  = YD;
            dif.OUT_READY = 1'b1;
            @(negedge CLK);
            CAP = 1'b0;
            YY  = '0;
            for (int k = 0; k < 4; k++) begin
                check_outputs($sformatf("sat%0d", k), 1'b1, sexp[k], 2'(k),
                              (k == 3), 1'b1, 1'b0);
                @(negedge CLK);
            end
            check_outputs("sat_end", 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        end

        // Capture on the last beat while the consumer stalls is an overflow, not a restart.
        begin
            int guard;
            CAP = 1'b1;
            YY  = YA;
            dif.OUT_READY = 1'b1;
            @(negedge CLK);
            CAP = 1'b0;
            guard = 0;
            while (!dif.OUT_LAST && guard < 10) begin
                @(negedge CLK);
                guard++;
            end
            chk("last_reached", 32'(dif.OUT_LAST), 32'h1);
            dif.OUT_READY = 1'b0;
            CAP = 1'b1;
            YY  = YB;
            @(negedge CLK);
            CAP = 1'b0;
            chk("stall_ovf",  32'(OVF),           32'h1);
            chk("stall_hold", 32'(dif.OUT_DATA),  32'(DW'(32'h4)));
            dif.OUT_READY = 1'b1;
            @(negedge CLK);
            chk("stall_idle", 32'(BUSY),          32'h0);
            chk("stall_ovf0", 32'(OVF),           32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
